// File: rtl/hram_ctrl_if.sv
// Request/response bus between the SoC memory mux and the HyperRAM controller.
interface hram_ctrl_if #(
  parameter int ADDR_W = 22
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_reg;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_wdata;
  logic [1:0]        req_wstrb;
  logic              rsp_valid;
  logic [15:0]       rsp_rdata;

  modport master (
    output req_valid, req_write, req_reg, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_reg, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/hram_ctrl.sv
// Single-word HyperRAM bus master: CA phase, latency, one 16-bit data word.
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// XFER  | CS low, beats of 2 clk (phase A: drive, phase B: toggle ck)
// TAIL  | one phase-A cycle after the last (falling) edge, lo read byte sampled
// DONE  | CS high, rsp_valid pulse
module hram_ctrl #(
  parameter int ADDR_W = 22
) (
  input  logic       clk_i,
  input  logic       reset_i,
  hram_ctrl_if.slave bus,
  output logic       hram_cs_o,
  output logic       hram_ck_o,
  output logic [7:0] dq_out_o,
  output logic       dq_oe_o,
  input  logic [7:0] dq_in_i,
  output logic       rwds_out_o,
  output logic       rwds_oe_o,
  input  logic       rwds_in_i
);
  typedef enum logic [1:0] {IDLE, XFER, TAIL, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  edge_q, edge_d;
  logic        phase_q, phase_d;
  logic [47:0] ca_q, ca_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  wstrb_q, wstrb_d;
  logic        write_q, write_d;
  logic        reg_q, reg_d;
  logic        lat_long_q, lat_long_d;
  logic [7:0]  rdata_hi_q, rdata_hi_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        cs_q, cs_d;
  logic        ck_q, ck_d;
  logic [7:0]  dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;
  logic        rwds_out_q, rwds_out_d;
  logic        rwds_oe_q, rwds_oe_d;

  logic [47:0] ca_w;
  logic [4:0]  lat_edge, last_edge, nxt;

  // CA word built straight from the request so B0 can be driven the cycle after accept
  assign ca_w = {~bus.req_write, bus.req_reg, 1'b1, 29'(bus.req_addr[ADDR_W-1:3]),
                 13'd0, bus.req_addr[2:0]};

  assign lat_edge  = lat_long_q ? 5'd20 : 5'd12;
  assign last_edge = reg_q ? 5'd7 : lat_edge + 5'd1;
  assign nxt       = edge_q + 5'd1;

  // State and pin registers; all pins come straight from flops
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      edge_q      <= '0;
      phase_q     <= 1'b0;
      ca_q        <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      write_q     <= 1'b0;
      reg_q       <= 1'b0;
      lat_long_q  <= 1'b0;
      rdata_hi_q  <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      cs_q        <= 1'b1;
      ck_q        <= 1'b0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      rwds_out_q  <= 1'b0;
      rwds_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      edge_q      <= edge_d;
      phase_q     <= phase_d;
      ca_q        <= ca_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      write_q     <= write_d;
      reg_q       <= reg_d;
      lat_long_q  <= lat_long_d;
      rdata_hi_q  <= rdata_hi_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      cs_q        <= cs_d;
      ck_q        <= ck_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      rwds_out_q  <= rwds_out_d;
      rwds_oe_q   <= rwds_oe_d;
    end
  end

  // Next state and next pin values; each XFER beat sets up the following beat's byte
  always_comb begin
    state_d     = state_q;
    edge_d      = edge_q;
    phase_d     = phase_q;
    ca_d        = ca_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    write_d     = write_q;
    reg_d       = reg_q;
    lat_long_d  = lat_long_q;
    rdata_hi_d  = rdata_hi_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    cs_d        = cs_q;
    ck_d        = ck_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = dq_oe_q;
    rwds_out_d  = rwds_out_q;
    rwds_oe_d   = rwds_oe_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          reg_d   = bus.req_reg;
          wdata_d = bus.req_wdata;
          wstrb_d = bus.req_wstrb;
          if (bus.req_reg && !bus.req_write) begin
            // register reads are unsupported: answer at once with zero, no bus activity
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rdata_d     = '0;
          end else begin
            state_d    = XFER;
            edge_d     = '0;
            phase_d    = 1'b0;
            lat_long_d = 1'b0;
            cs_d       = 1'b0;
            dq_oe_d    = 1'b1;
            dq_out_d   = ca_w[47:40];
            ca_d       = ca_w << 8;
          end
        end
      end
      XFER: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          ck_d    = ~ck_q;
          if (edge_q == 5'd3) lat_long_d = rwds_in_i;
          if (!write_q && !reg_q && edge_q == lat_edge + 5'd1) rdata_hi_d = dq_in_i;
        end else if (edge_q == last_edge) begin
          state_d = TAIL;
          phase_d = 1'b0;
        end else begin
          phase_d = 1'b0;
          edge_d  = nxt;
          if (nxt <= 5'd5) begin
            dq_out_d = ca_q[47:40];
            ca_d     = ca_q << 8;
          end else if (reg_q) begin
            dq_out_d = (nxt == 5'd6) ? wdata_q[15:8] : wdata_q[7:0];
          end else if (write_q) begin
            rwds_oe_d = (nxt >= lat_edge);
            if (nxt == lat_edge) begin
              dq_out_d   = wdata_q[15:8];
              rwds_out_d = wstrb_q[1];
            end else if (nxt == lat_edge + 5'd1) begin
              dq_out_d   = wdata_q[7:0];
              rwds_out_d = wstrb_q[0];
            end else begin
              dq_out_d = '0;
            end
          end else begin
            dq_oe_d = 1'b0;
          end
        end
      end
      TAIL: begin
        state_d     = DONE;
        cs_d        = 1'b1;
        dq_oe_d     = 1'b0;
        rwds_oe_d   = 1'b0;
        dq_out_d    = '0;
        rwds_out_d  = 1'b0;
        rsp_valid_d = 1'b1;
        if (!write_q) rdata_d = {rdata_hi_q, dq_in_i};
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign hram_cs_o     = cs_q;
  assign hram_ck_o     = ck_q;
  assign dq_out_o      = dq_out_q;
  assign dq_oe_o       = dq_oe_q;
  assign rwds_out_o    = rwds_out_q;
  assign rwds_oe_o     = rwds_oe_q;
endmodule
